// File: rtl/jump_inst_encoder_if.sv
// jump_inst_encoder_if
//   Request/response bundle for the JAL/JALR instruction encoder.
//   Also defines the codebase jump_ctrl codes `JAL and `JALR if they are not
//   already defined.
//   Signals:
//     in_valid/in_ready   request handshake
//     in_rd, in_rs1       register fields (rs1 used by JALR only)
//     in_imm[20:0]        signed byte offset
//     in_jump_ctrl[1:0]   `JAL or `JALR; other codes are rejected
//     out_valid/out_ready encoded word handshake
//     out_inst[31:0]      encoded instruction word (FIFO head)
//     err_pulse           one-cycle pulse per rejected request
//     enc_count/err_count wrapping word/reject counters
//   Modports: master = stimulus side, slave = encoder side.

`ifndef JAL
`define JAL 2'b01
`endif
`ifndef JALR
`define JALR 2'b10
`endif

interface jump_inst_encoder_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [20:0]      in_imm;
  logic [1:0]       in_jump_ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic             err_pulse;
  logic [CNT_W-1:0] enc_count;
  logic [CNT_W-1:0] err_count;

  modport master (
    output in_valid, in_rd, in_rs1, in_imm, in_jump_ctrl, out_ready,
    input  in_ready, out_valid, out_inst, err_pulse, enc_count, err_count
  );

  modport slave (
    input  in_valid, in_rd, in_rs1, in_imm, in_jump_ctrl, out_ready,
    output in_ready, out_valid, out_inst, err_pulse, enc_count, err_count
  );
endinterface

// File: rtl/jump_inst_encoder.sv
// jump_inst_encoder
//   Builds RV32I JAL/JALR words from rd/rs1/imm/jump_ctrl fields. A request is
//   legality-checked at accept, encoded into a one-word stage register, then
//   moved into a DEPTH-entry output FIFO. Rejected requests produce err_pulse
//   and bump err_count instead of a word.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  jump_inst_encoder_if.slave (request, response, status counters)
//   Parameters:
//     DEPTH  output FIFO entries (power of 2, >= 2)
//     CNT_W  width of enc_count / err_count

module jump_inst_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  jump_inst_encoder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;
  logic             r_stg_valid;
  logic [31:0]      r_stg_inst;
  logic [31:0]      r_last;
  logic             r_err_pulse;
  logic [CNT_W-1:0] r_enc_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic        w_jal;
  logic        w_jalr;
  logic        w_legal;
  logic [31:0] w_enc;
  logic        w_full;
  logic        w_empty;
  logic        w_in_ready;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;

  assign w_jal  = (bus.in_jump_ctrl == `JAL);
  assign w_jalr = (bus.in_jump_ctrl == `JALR);

  // JALR offset must fit a 12-bit signed field: upper bits are pure sign copies.
  assign w_legal = (w_jal  && !bus.in_imm[0]) ||
                   (w_jalr && (bus.in_imm[20:12] == {9{bus.in_imm[11]}}));

  assign w_enc = w_jal ?
    {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11], bus.in_imm[19:12],
     bus.in_rd, 7'b1101111} :
    {bus.in_imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, 7'b1100111};

  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_empty = (r_cnt == '0);

  // Built from registered state only, so out_ready never reaches in_ready.
  assign w_in_ready = !(r_stg_valid && w_full);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_push     = r_stg_valid && !w_full;
  assign w_pop      = !w_empty && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_cnt       <= '0;
      r_stg_valid <= 1'b0;
      r_stg_inst  <= '0;
      r_last      <= '0;
      r_err_pulse <= 1'b0;
      r_enc_cnt   <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_err_pulse <= w_accept && !w_legal;
      if (w_accept && !w_legal) r_err_cnt <= r_err_cnt + CNT_W'(1);

      // A new accept may refill the stage in the same cycle it drains.
      if (w_accept && w_legal) begin
        r_stg_valid <= 1'b1;
        r_stg_inst  <= w_enc;
      end else if (w_push) begin
        r_stg_valid <= 1'b0;
      end

      if (w_push) begin
        r_mem[r_wptr] <= r_stg_inst;
        r_wptr        <= r_wptr + AW'(1);
        r_enc_cnt     <= r_enc_cnt + CNT_W'(1);
      end

      // Remember the departing head so out_inst is stable once empty.
      if (w_pop) begin
        r_last <= r_mem[r_rptr];
        r_rptr <= r_rptr + AW'(1);
      end

      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = !w_empty;
  assign bus.out_inst  = w_empty ? r_last : r_mem[r_rptr];
  assign bus.err_pulse = r_err_pulse;
  assign bus.enc_count = r_enc_cnt;
  assign bus.err_count = r_err_cnt;
endmodule
